// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants for the iterative
// RV32M multiply/divide sequencer.
package muldiv_pkg;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  localparam logic [2:0] ALU_OP_ADDSUB = 3'b000;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PREP_A = 3'd1,
    S_PREP_B = 3'd2,
    S_ITER   = 3'd3,
    S_FIX    = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  function automatic logic a_signed(
    input logic [2:0] f
  );
    return f inside {MD_MUL, MD_MULH,
                     MD_MULHSU, MD_DIV,
                     MD_REM};
  endfunction

  function automatic logic b_signed(
    input logic [2:0] f
  );
    return f inside {MD_MUL, MD_MULH,
                     MD_DIV, MD_REM};
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add / restoring-divide
// iteration built around the shared ALU result.
module muldiv_step (
  input  logic        is_div,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  input  logic        b31,
  input  logic [31:0] r,
  output logic [31:0] nhi,
  output logic [31:0] nlo
);

  logic carry;
  logic borrow;
  logic ge;

  // carry/borrow recovered from operand and sum MSBs
  always_comb begin
    carry  = (hi[31] & b31)
           | ((hi[31] | b31) & ~r[31]);
    borrow = (~hi[30] & b31)
           | ((~hi[30] | b31) & r[31]);
    ge     = hi[31] | ~borrow;
    if (is_div) begin
      nhi = ge ? r : {hi[30:0], lo[31]};
      nlo = {lo[30:0], ge};
    end else begin
      nhi = {carry, r[31:1]};
      nlo = {r[0], lo[31:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: 36-cycle RV32M sequencer that borrows
// the execute-stage ALU adder while busy.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  output logic             alu_control,
  input  logic [WIDTH-1:0] alu_result
);

  state_t state;
  state_t state_n;

  logic [2:0]       fn;
  logic [WIDTH-1:0] a_raw;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH-1:0] b_fix;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi_n;
  logic [WIDTH-1:0] lo_n;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] fixed;
  logic [4:0]       cnt;
  logic             sa;
  logic             sb;
  logic             div0;
  logic             ovf;
  logic             neg;
  logic             is_div;
  logic             is_rem;
  logic             is_mulh;

  assign is_div  = fn[2];
  assign is_rem  = fn[2] & fn[1];
  assign is_mulh = ~fn[2] & (fn[1] | fn[0]);
  assign alu_op  = ALU_OP_ADDSUB;
  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);
  assign b_fix   = sb ? alu_result : b_abs;

  muldiv_step u_step (
    .is_div (is_div),
    .hi     (hi),
    .lo     (lo),
    .b31    (alu_b[31]),
    .r      (alu_result),
    .nhi    (hi_n),
    .nlo    (lo_n)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // next-state: fixed walk, flush aborts to IDLE
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:
        if (start && !flush) state_n = S_PREP_A;
      S_PREP_A: state_n = S_PREP_B;
      S_PREP_B: state_n = S_ITER;
      S_ITER:
        if (cnt == 5'd31) state_n = S_FIX;
      S_FIX:    state_n = S_DONE;
      S_DONE:   state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
    if (flush && state != S_IDLE) begin
      state_n = S_IDLE;
    end
  end

  // ALU operand/control drive per state
  always_comb begin
    alu_a       = '0;
    alu_b       = '0;
    alu_control = 1'b0;
    unique case (state)
      S_PREP_A: begin
        alu_b       = a_raw;
        alu_control = 1'b1;
      end
      S_PREP_B: begin
        alu_b       = b_abs;
        alu_control = 1'b1;
      end
      S_ITER: begin
        if (is_div) begin
          alu_a       = {hi[30:0], lo[31]};
          alu_b       = b_abs;
          alu_control = 1'b1;
        end else begin
          alu_a = hi;
          alu_b = lo[0] ? a_abs : '0;
        end
      end
      S_FIX: begin
        if (is_mulh) begin
          alu_a = ~hi;
          alu_b = {31'b0, lo == '0};
        end else begin
          alu_b       = word;
          alu_control = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // final word selection, sign fix, special cases
  always_comb begin
    word = lo;
    if (is_rem || is_mulh) word = hi;
    neg   = is_rem ? sa : (sa ^ sb);
    fixed = neg ? alu_result : word;
    if (is_div && div0) begin
      fixed = is_rem ? a_raw : '1;
    end else if (ovf) begin
      fixed = is_rem ? '0 : 32'h8000_0000;
    end
  end

  // operand latch and iteration datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      fn     <= '0;
      a_raw  <= '0;
      a_abs  <= '0;
      b_abs  <= '0;
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      div0   <= 1'b0;
      ovf    <= 1'b0;
      result <= '0;
    end else if (!flush) begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            fn    <= funct3;
            a_raw <= rs1;
            b_abs <= rs2;
            sa    <= a_signed(funct3) & rs1[31];
            sb    <= b_signed(funct3) & rs2[31];
            div0  <= (rs2 == '0);
            ovf   <= (funct3 == MD_DIV
                   || funct3 == MD_REM)
                   && rs1 == 32'h8000_0000
                   && rs2 == 32'hFFFF_FFFF;
          end
        end
        S_PREP_A: a_abs <= sa ? alu_result : a_raw;
        S_PREP_B: begin
          b_abs <= b_fix;
          hi    <= '0;
          lo    <= is_div ? a_abs : b_fix;
          cnt   <= '0;
        end
        S_ITER: begin
          hi  <= hi_n;
          lo  <= lo_n;
          cnt <= cnt + 5'd1;
        end
        S_FIX:   result <= fixed;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed and randomized checks of
// muldiv_seq against an arithmetic reference.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        flush;
  logic [2:0]  funct3;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic        alu_control;
  logic [31:0] alu_result;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign alu_result = alu_control ? alu_a - alu_b
                                  : alu_a + alu_b;

  muldiv_seq dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .flush       (flush),
    .funct3      (funct3),
    .rs1         (rs1),
    .rs2         (rs2),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_control (alu_control),
    .alu_result  (alu_result)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(
    input logic [2:0]  f,
    input logic [31:0] a,
    input logic [31:0] b
  );
    longint      sa;
    longint      sb;
    longint      ub;
    logic [63:0] p;
    logic        ov;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    ov = (a == 32'h8000_0000)
      && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin
        p = 64'(sa * sb);
        return p[31:0];
      end
      3'd1: begin
        p = 64'(sa * sb);
        return p[63:32];
      end
      3'd2: begin
        p = 64'(sa * ub);
        return p[63:32];
      end
      3'd3: begin
        p = {32'b0, a} * {32'b0, b};
        return p[63:32];
      end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ov) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (ov) return 32'h0;
        return 32'(sa % sb);
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  task automatic do_op(
    input string       tag,
    input logic [2:0]  f,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] exp,
    input int          poke
  );
    int lat;
    lat = 0;
    @(negedge clk);
    start  = 1'b1;
    funct3 = f;
    rs1    = a;
    rs2    = b;
    @(negedge clk);
    start  = 1'b0;
    rs1    = $urandom;
    rs2    = $urandom;
    funct3 = 3'($urandom);
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      if (k > 1) @(negedge clk);
      if (start) start = 1'b0;
      if (done) begin
        lat = k;
      end else if (k < 36) begin
        chk({tag, ".busy"}, 32'(busy), 1);
        chk({tag, ".aluop"}, 32'(alu_op), 0);
      end
      if (k == poke) begin
        start  = 1'b1;
        rs1    = $urandom;
        rs2    = $urandom;
        funct3 = 3'($urandom);
      end
    end
    if (lat == 0) lat = 41;
    chk({tag, ".lat"}, 32'(lat), 36);
    chk({tag, ".res"}, result, exp);
    @(negedge clk);
    start = 1'b0;
    chk({tag, ".idle"}, 32'(busy), 0);
    chk({tag, ".hold"}, result, exp);
  endtask

  initial begin
    int          saw;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    rst    = 1'b1;
    start  = 1'b0;
    flush  = 1'b0;
    funct3 = '0;
    rs1    = '0;
    rs2    = '0;
    repeat (3) @(negedge clk);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.done", 32'(done), 0);
    chk("rst.res", result, 0);
    chk("rst.alua", alu_a, 0);
    chk("rst.alub", alu_b, 0);
    chk("rst.ctl", 32'(alu_control), 0);
    rst = 1'b0;

    do_op("mul", 3'd0, 7, 6, 32'h2A, 0);
    do_op("mulh", 3'd1, 32'h8000_0000,
          32'h8000_0000, 32'h4000_0000, 0);
    do_op("mulhu", 3'd3, 32'hFFFF_FFFF,
          32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
    do_op("mulhsu", 3'd2, 32'hFFFF_FFFF,
          2, 32'hFFFF_FFFF, 0);
    do_op("div", 3'd4, -32'sd7, 2,
          32'hFFFF_FFFD, 0);
    do_op("rem", 3'd6, -32'sd7, 2,
          32'hFFFF_FFFF, 0);
    do_op("divu", 3'd5, 100, 7, 14, 0);
    do_op("remu", 3'd7, 100, 7, 2, 36);
    do_op("divu0", 3'd5, 5, 0,
          32'hFFFF_FFFF, 0);
    do_op("remu0", 3'd7, 5, 0, 5, 0);
    do_op("divovf", 3'd4, 32'h8000_0000,
          32'hFFFF_FFFF, 32'h8000_0000, 0);
    do_op("removf", 3'd6, 32'h8000_0000,
          32'hFFFF_FFFF, 0, 0);

    @(negedge clk);
    start  = 1'b1;
    funct3 = 3'd0;
    rs1    = 5;
    rs2    = 9;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    chk("fl.busy_pre", 32'(busy), 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fl.busy", 32'(busy), 0);
    saw = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) saw = 1;
    end
    chk("fl.nodone", 32'(saw), 0);
    chk("fl.res", result, 0);

    do_op("mul33", 3'd0, 3, 3, 9, 0);
    do_op("poke", 3'd5, 100, 7, 14, 5);

    @(negedge clk);
    start  = 1'b1;
    funct3 = 3'd4;
    rs1    = 1000;
    rs2    = 3;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rr.busy", 32'(busy), 0);
    chk("rr.done", 32'(done), 0);
    chk("rr.res", result, 0);
    chk("rr.ctl", 32'(alu_control), 0);
    rst = 1'b0;

    for (int i = 0; i < 60; i++) begin
      f = 3'($urandom);
      a = pick();
      b = pick();
      do_op($sformatf("rnd%0d_f%0d", i, f),
            f, a, b, model(f, a, b), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
